// File: rtl/spart_word_assembler.sv
// spart_word_assembler
//   Rebuilds 16-bit words from the SPART receive byte stream (low byte first,
//   then high byte) and buffers them in a small first-word-fall-through FIFO
//   that feeds the spart input of the writeback source select.
//
// Ports
//   clk, rst_n    : system clock, asynchronous active-low reset
//   rx_valid      : one-cycle strobe, rx_byte valid this cycle
//   rx_byte[7:0]  : received byte
//   rd_en         : pop the head word (ignored when empty)
//   flush         : synchronous clear of FIFO and assembly state
//   word_out[15:0]: head word, 16'h0000 when empty
//   word_valid    : FIFO not empty
//   count[CW-1:0] : words stored
//   half_pending  : low byte held, waiting for its high byte
//   overflow      : sticky, a completed word was dropped on a full FIFO
//   timeout_drop  : (SPART_ASM_TIMEOUT_EN only) one-cycle pulse when a lone
//                   low byte was discarded after TIMEOUT idle cycles
//
// Optional feature macro: SPART_ASM_TIMEOUT_EN
//
// state     | meaning
// LOW_WAIT  | no byte held, next rx byte is a low byte
// HIGH_WAIT | low byte held, next rx byte completes a word
module spart_word_assembler #(
  parameter int DEPTH   = 4,
  parameter int CW      = $clog2(DEPTH + 1),
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  input  logic          rd_en,
  input  logic          flush,
  output logic [15:0]   word_out,
  output logic          word_valid,
  output logic [CW-1:0] count,
  output logic          half_pending,
  output logic          overflow
`ifdef SPART_ASM_TIMEOUT_EN
  ,
  output logic          timeout_drop
`endif
);

  localparam logic [0:0] LOW_WAIT  = 1'b0;
  localparam logic [0:0] HIGH_WAIT = 1'b1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [0:0]    state_q, state_d;
  logic [7:0]    low_q, low_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];

  logic empty, full, pop, push_try, push_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = rd_en && !empty;
  assign push_try = (state_q == HIGH_WAIT) && rx_valid;
  // A full FIFO still accepts the word when the head leaves in the same cycle.
  assign push_ok  = push_try && (!full || rd_en);

`ifdef SPART_ASM_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          drop_q, drop_d;
`endif

  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    mem_d   = mem_q;
`ifdef SPART_ASM_TIMEOUT_EN
    tmo_d   = tmo_q;
    drop_d  = 1'b0;
`endif
    if (flush) begin
      state_d = LOW_WAIT;
      low_d   = 8'h00;
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
`ifdef SPART_ASM_TIMEOUT_EN
      tmo_d   = '0;
`endif
    end else begin
      if (state_q == LOW_WAIT) begin
        if (rx_valid) begin
          low_d   = rx_byte;
          state_d = HIGH_WAIT;
`ifdef SPART_ASM_TIMEOUT_EN
          tmo_d   = TW'(TIMEOUT - 1);
`endif
        end
      end else begin
        if (rx_valid) begin
          state_d = LOW_WAIT;
`ifdef SPART_ASM_TIMEOUT_EN
        end else if (tmo_q == '0) begin
          // TIMEOUT idle cycles elapsed: give up on the held low byte.
          state_d = LOW_WAIT;
          drop_d  = 1'b1;
        end else begin
          tmo_d   = tmo_q - 1'b1;
`endif
        end
      end

      if (push_ok) begin
        mem_d[wr_q] = {rx_byte, low_q};
        wr_d        = wr_q + 1'b1;
      end else if (push_try) begin
        ovf_d = 1'b1;
      end

      if (pop) rd_d = rd_q + 1'b1;

      count_d = count_q + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW_WAIT;
      low_q   <= 8'h00;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      mem_q   <= '{default: 16'h0000};
`ifdef SPART_ASM_TIMEOUT_EN
      tmo_q   <= '0;
      drop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
`ifdef SPART_ASM_TIMEOUT_EN
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
`endif
    end
  end

  // Empty forces zero so a popped entry is never shown again.
  assign word_out     = empty ? 16'h0000 : mem_q[rd_q];
  assign word_valid   = !empty;
  assign count        = count_q;
  assign half_pending = (state_q == HIGH_WAIT);
  assign overflow     = ovf_q;
`ifdef SPART_ASM_TIMEOUT_EN
  assign timeout_drop = drop_q;
`endif

endmodule

// File: tb/tb_spart_word_assembler.sv
module tb_spart_word_assembler;

  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic [15:0]   word_out;
  logic          word_valid;
  logic [CW-1:0] count;
  logic          half_pending;
  logic          overflow;
`ifdef SPART_ASM_TIMEOUT_EN
  logic          timeout_drop;
`endif

  spart_word_assembler #(.DEPTH(DEPTH), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rd_en        (rd_en),
    .flush        (flush),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .count        (count),
    .half_pending (half_pending),
    .overflow     (overflow)
`ifdef SPART_ASM_TIMEOUT_EN
    ,
    .timeout_drop (timeout_drop)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of completed words plus the pending-byte state.
  logic [15:0] mq[$];
  bit          m_half;
  logic [7:0]  m_low;
  bit          m_ovf;
  int          m_idle;
  bit          m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_half = 0;
    m_low  = 8'h00;
    m_ovf  = 0;
    m_idle = 0;
    m_drop = 0;
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_word;
    exp_word = (mq.size() > 0) ? mq[0] : 16'h0000;
    check({tag, ".word_valid"},   word_valid,   (mq.size() > 0));
    check({tag, ".word_out"},     word_out,     exp_word);
    check({tag, ".count"},        count,        mq.size());
    check({tag, ".half_pending"}, half_pending, m_half);
    check({tag, ".overflow"},     overflow,     m_ovf);
`ifdef SPART_ASM_TIMEOUT_EN
    check({tag, ".timeout_drop"}, timeout_drop, m_drop);
`endif
  endtask

  task automatic model_cycle(input bit rxv, input logic [7:0] b, input bit rd, input bit fl);
    bit popped;
    int sz;
    m_drop = 0;
    if (fl) begin
      model_reset();
      return;
    end
    sz     = mq.size();
    popped = rd && (sz > 0);
    if (popped) void'(mq.pop_front());
    if (rxv) begin
      if (!m_half) begin
        m_low  = b;
        m_half = 1;
        m_idle = 0;
      end else begin
        m_half = 0;
        if (sz < DEPTH || popped) mq.push_back({b, m_low});
        else m_ovf = 1;
      end
    end else if (m_half) begin
`ifdef SPART_ASM_TIMEOUT_EN
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_half = 0;
        m_drop = 1;
      end
`endif
    end
  endtask

  // Called at a falling edge; drives one cycle, then checks at the next falling edge.
  task automatic step(input string tag, input bit rxv, input logic [7:0] b, input bit rd, input bit fl);
    rx_valid = rxv;
    rx_byte  = b;
    rd_en    = rd;
    flush    = fl;
    @(posedge clk);
    model_cycle(rxv, b, rd, fl);
    @(negedge clk);
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    flush    = 1'b0;
    check_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [15:0] w, input bit rd_on_high);
    step(tag, 1'b1, w[7:0], 1'b0, 1'b0);
    step(tag, 1'b1, w[15:8], rd_on_high, 1'b0);
  endtask

  initial begin
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic assembly and pop.
    send_word("basic", 16'h1234, 1'b0);
    check("basic.word", word_out, 16'h1234);
    step("basic_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    check("basic_pop.word", word_out, 16'h0000);

    // Overflow on the fifth word, then in-order drain.
    for (int i = 1; i <= 5; i++) send_word("fill", 16'(i), 1'b0);
    check("fill.count", count, 4);
    check("fill.overflow", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      check("drain.word", word_out, 16'(i));
      step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Full FIFO, high byte arrives together with a pop.
    step("flush1", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_word("full", 16'hA000 + 16'(i), 1'b0);
    send_word("full_pp", 16'hBEEF, 1'b1);
    check("full_pp.count", count, 4);
    check("full_pp.overflow", overflow, 0);
    for (int i = 0; i < 4; i++) step("full_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Flush mid-word drops the held low byte.
    step("fl_low", 1'b1, 8'hAA, 1'b0, 1'b0);
    step("fl", 1'b1, 8'h99, 1'b1, 1'b1);
    check("fl.half", half_pending, 0);
    send_word("fl_word", 16'h6655, 1'b0);
    check("fl_word.word", word_out, 16'h6655);
    step("fl2", 1'b0, 8'h00, 1'b0, 1'b1);

    // Pops on empty are ignored.
    for (int i = 0; i < 3; i++) step("empty_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    send_word("after_empty", 16'hC3D4, 1'b1);
    check("after_empty.word", word_out, 16'hC3D4);
    step("fl3", 1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset in HIGH_WAIT.
    step("rst_low", 1'b1, 8'hAB, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SPART_ASM_TIMEOUT_EN
    step("tmo_low", 1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT + 2; i++) step("tmo_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    send_word("tmo_word", 16'h3322, 1'b0);
    check("tmo_word.word", word_out, 16'h3322);
    step("fl4", 1'b0, 8'h00, 1'b0, 1'b1);
`endif

    // Randomized traffic in phases of differing pop pressure.
    for (int i = 0; i < 1500; i++) begin
      bit rxv, rd, fl;
      rxv = ($urandom % 2) == 0;
      if (i < 500)       rd = ($urandom % 5) == 0;
      else if (i < 1000) rd = ($urandom % 2) == 0;
      else               rd = ($urandom % 5) != 0;
      fl = ($urandom % 80) == 0;
      step("rand", rxv, 8'($urandom), rd, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spart_word_assembler.md
Name: spart_word_assembler

Overview:
- Receive-side counterpart of the processor's byte-split SPART transmit path. Transmit sends a 16-bit register as low byte, then high byte.
- This block collects bytes from the SPART receiver in that same order (low byte first) and rebuilds 16-bit words.
- Completed words are buffered in a small first-word-fall-through (FWFT) FIFO.
- The processor pops words from the FIFO, and they feed the spart input of the writeback source select.

Parameters:
- DEPTH, 4, number of 16-bit word entries in the FIFO; power of two, 2..16.
- CW, $clog2(DEPTH+1), width of the occupancy count.
- TIMEOUT, 1024, cycles a lone low byte may wait for its high byte (used only with the optional feature).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_valid  input  1  one-cycle strobe from the SPART receiver: rx_byte is valid this cycle.
- rx_byte  input  8  received byte.
- rd_en  input  1  processor pop request for the head word.
- flush  input  1  synchronous clear of FIFO and assembly state.
- word_out  output  16  head word of the FIFO (FWFT); 16'h0000 when empty.
- word_valid  output  1  FIFO not empty.
- count  output  CW  number of words stored.
- half_pending  output  1  low byte held, waiting for high byte.
- overflow  output  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State machine to LOW_WAIT; low-byte register to 8'h00.
  - FIFO pointers and count to 0; word_out=16'h0000.
  - word_valid=0, half_pending=0, overflow=0.
- State machine, two states:
  - LOW_WAIT: on rx_valid, latch rx_byte as the low byte and go to HIGH_WAIT.
  - HIGH_WAIT: on rx_valid, form {rx_byte, low_byte}, attempt a push, then go to LOW_WAIT.
  - half_pending=1 exactly when in HIGH_WAIT.
- Push rules:
  - The push is accepted if count<DEPTH, or if count==DEPTH and rd_en=1 in the same cycle (pop and push together, count unchanged).
  - Otherwise the word is discarded and overflow is set.
  - overflow clears only on reset or flush.
- Latency: a word is visible on word_out with word_valid=1 on the cycle after the rx_valid that carried its high byte, provided the FIFO was empty.
- Pop:
  - rd_en with word_valid=1 advances the head on the next edge.
  - rd_en with the FIFO empty is ignored; no pointer movement, no error flag.
- Simultaneous push and pop with count>0: count unchanged, order preserved.
- Simultaneous push and pop with count==0: the push lands and the pop is ignored; count goes to 1.
- Pointers wrap modulo DEPTH; count saturates by construction at DEPTH.
- word_out is driven from the registered head entry. It is zero when empty, never stale data.
- flush (highest priority after reset):
  - Clears FIFO, count, overflow; forces LOW_WAIT.
  - Any rx_valid or rd_en in the same cycle is ignored.
- Reset asserted mid-word (HIGH_WAIT): the partial low byte is lost and the block returns to LOW_WAIT.

Optional Feature:
- Macro: SPART_ASM_TIMEOUT_EN.
- Defined:
  - A counter runs while in HIGH_WAIT and resets on every rx_valid.
  - After TIMEOUT consecutive cycles without rx_valid, the held low byte is discarded and the block returns to LOW_WAIT.
  - A one-cycle output pulse timeout_drop (1 bit, extra port present only when defined) is asserted on that cycle.
  - flush and reset clear the counter.
- Undefined:
  - No counter and no timeout_drop port.
  - HIGH_WAIT is held indefinitely until the next rx_valid.

Test Plan:
- Reset, then rx bytes 8'h34 then 8'h12 -> next cycle word_valid=1, word_out=16'h1234, count=1; rd_en 1 cycle -> word_valid=0, word_out=16'h0000.
- Five words 16'h0001..16'h0005 with DEPTH=4 and no pops -> count=4, overflow=1; pops return 0001,0002,0003,0004 in order.
- FIFO full, high byte arrives while rd_en=1 -> count stays 4, new word at tail, overflow stays 0.
- Low byte 8'hAA, flush, then bytes 8'h55, 8'h66 -> word_out=16'h6655, half_pending=0 after the flush cycle.
- rd_en on empty FIFO for 3 cycles -> count=0, overflow=0, pointers unchanged; a subsequent push reads back correctly.
- With SPART_ASM_TIMEOUT_EN and TIMEOUT=16: low byte 8'h11, idle 16 cycles -> timeout_drop pulses once; then 8'h22, 8'h33 -> word_out=16'h3322.
